// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and default width for the iterative divider
package div_pkg;

   localparam int DIV_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract iteration of the divider
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           borrow;

   assign shifted         = {rem_in[WIDTH-1:0], dividend_bit};
   assign {borrow, diff}  = {1'b0, shifted} - {2'b00, divisor};
   // a set top bit means the shifted value already exceeds any WIDTH-bit divisor
   assign q_bit           = ~borrow | rem_in[WIDTH];
   assign rem_out         = q_bit ? diff : shifted;

endmodule

// File: rtl/iter_div.sv
// rtl/iter_div.sv - iterative restoring divider, one quotient bit per cycle
// Optional ITER_DIV_ZERO_BYPASS_EN: a zero divisor skips the iterations.
module iter_div
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             op_signed,
   input  logic             op_rem,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);

   div_state_e       state;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   rem_next;
   logic [CNT_W-1:0] cnt;
   logic             q_bit;
   logic             neg_q;
   logic             neg_r;
   logic             sel_rem;
   logic             accept;
   logic             last;
   logic [WIDTH-1:0] abs1;
   logic [WIDTH-1:0] abs2;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;
   logic [WIDTH-1:0] res_fin;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign accept    = in_valid & in_ready & ~flush;
   assign last      = (cnt == CNT_W'(WIDTH - 1));

   assign abs1 = (op_signed & src1[WIDTH-1]) ? -src1 : src1;
   assign abs2 = (op_signed & src2[WIDTH-1]) ? -src2 : src2;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in       (rem),
      .dividend_bit (quo[WIDTH-1]),
      .divisor      (dvs),
      .rem_out      (rem_next),
      .q_bit        (q_bit)
   );

   assign q_fin   = {quo[WIDTH-2:0], q_bit};
   assign r_fin   = rem_next[WIDTH-1:0];
   assign res_fin = sel_rem ? (neg_r ? -r_fin : r_fin)
                            : (neg_q ? -q_fin : q_fin);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         cnt     <= '0;
         result  <= '0;
         quo     <= '0;
         rem     <= '0;
         dvs     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         sel_rem <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  quo     <= abs1;
                  dvs     <= abs2;
                  rem     <= '0;
                  cnt     <= '0;
                  sel_rem <= op_rem;
                  // divide-by-zero keeps the all-ones quotient unsigned-looking
                  neg_q   <= op_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]) & (|src2);
                  neg_r   <= op_signed & src1[WIDTH-1];
`ifdef ITER_DIV_ZERO_BYPASS_EN
                  if (src2 == '0) begin
                     state  <= DONE;
                     result <= op_rem ? src1 : '1;
                  end else begin
                     state <= CALC;
                  end
`else
                  state <= CALC;
`endif
               end
            end
            CALC: begin
               rem <= rem_next;
               quo <= q_fin;
               cnt <= cnt + 1'b1;
               if (last) begin
                  state  <= DONE;
                  result <= res_fin;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_div.sv
// tb/tb_iter_div.sv - self-checking bench for iter_div (table vectors plus corner sequences)
module tb_iter_div;

   localparam int W = 32;
`ifdef ITER_DIV_ZERO_BYPASS_EN
   localparam int ZL = 1;
`else
   localparam int ZL = W + 1;
`endif
   localparam int NL = W + 1;

   typedef struct {
      logic        sgn;
      logic        rem;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   logic          clk;
   logic          resetn;
   logic          in_valid;
   logic          in_ready;
   logic          op_signed;
   logic          op_rem;
   logic [W-1:0]  src1;
   logic [W-1:0]  src2;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          busy;

   int            checks;
   int            errors;
   logic [31:0]   sb[$];
   vec_t          vecs[16];

   iter_div #(.WIDTH(W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_signed (op_signed),
      .op_rem    (op_rem),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic sgn, input logic rem,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      if (b == 32'd0) r = rem ? a : 32'hFFFF_FFFF;
      else if (sgn && rem) r = $signed(a) % $signed(b);
      else if (sgn) r = $signed(a) / $signed(b);
      else if (rem) r = a % b;
      else r = a / b;
      return r;
   endfunction

   task automatic do_op(input string name, input vec_t v);
      int lat;
      logic [31:0] want;
      op_signed = v.sgn;
      op_rem    = v.rem;
      src1      = v.a;
      src2      = v.b;
      in_valid  = 1'b1;
      check({name, ".in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      src1     = $urandom;
      src2     = $urandom;
      sb.push_back(v.exp);
      lat = 1;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      check({name, ".lat"}, lat, v.lat);
      want = sb.pop_front();
      check({name, ".result"}, result, want);
      tick();
      check({name, ".idle"}, {out_valid, in_ready}, 2'b01);
   endtask

   initial begin
      int lat;
      int seen;
      vec_t v;
      checks    = 0;
      errors    = 0;
      resetn    = 1'b0;
      in_valid  = 1'b0;
      op_signed = 1'b0;
      op_rem    = 1'b0;
      src1      = '0;
      src2      = '0;
      flush     = 1'b0;
      out_ready = 1'b1;

      vecs[0]  = '{1'b0, 1'b0, 32'd7,          32'd2,          32'd3,          NL};
      vecs[1]  = '{1'b0, 1'b1, 32'd7,          32'd2,          32'd1,          NL};
      vecs[2]  = '{1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  NL};
      vecs[3]  = '{1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  NL};
      vecs[4]  = '{1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  NL};
      vecs[5]  = '{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          NL};
      vecs[6]  = '{1'b1, 1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  ZL};
      vecs[7]  = '{1'b1, 1'b1, 32'd5,          32'd0,          32'd5,          ZL};
      vecs[8]  = '{1'b0, 1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  ZL};
      vecs[9]  = '{1'b0, 1'b1, 32'd5,          32'd0,          32'd5,          ZL};
      vecs[10] = '{1'b1, 1'b0, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  ZL};
      vecs[11] = '{1'b1, 1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  ZL};
      vecs[12] = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  NL};
      vecs[13] = '{1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          NL};
      vecs[14] = '{1'b0, 1'b0, 32'd100,        32'd7,          32'd14,         NL};
      vecs[15] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  NL};

      repeat (3) @(posedge clk);
      #1;
      check("reset.in_ready", in_ready, 1);
      check("reset.out_valid", out_valid, 0);
      check("reset.busy", busy, 0);
      check("reset.result", result, 0);
      resetn = 1'b1;
      tick();

      for (int i = 0; i < 16; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i]);
      end

      for (int i = 0; i < 8; i++) begin
         v.sgn = 1'($urandom_range(0, 1));
         v.rem = 1'($urandom_range(0, 1));
         v.a   = $urandom;
         v.b   = $urandom_range(1, 50000);
         if ($urandom_range(0, 1) == 1) v.b = -v.b;
         if (v.a == 32'h8000_0000) v.a = 32'd1;
         v.exp = model(v.sgn, v.rem, v.a, v.b);
         v.lat = NL;
         do_op($sformatf("rnd%0d", i), v);
      end

      out_ready = 1'b0;
      op_signed = 1'b0;
      op_rem    = 1'b0;
      src1      = 32'd100;
      src2      = 32'd7;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      sb.push_back(32'd14);
      lat = 1;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      check("bp.lat", lat, NL);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("bp.hold%0d", i), {out_valid, in_ready, result}, {2'b10, sb[0]});
         tick();
      end
      out_ready = 1'b1;
      check("bp.hs_in_ready", in_ready, 0);
      tick();
      check("bp.after_hs", {out_valid, in_ready}, 2'b01);
      void'(sb.pop_front());

      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      check("flush_idle.busy", busy, 0);
      in_valid = 1'b0;
      flush    = 1'b0;

      src1     = 32'd1000;
      src2     = 32'd3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      check("flush.busy_before", busy, 1);
      flush    = 1'b1;
      in_valid = 1'b1;
      src1     = 32'd9;
      src2     = 32'd2;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush.idle", {busy, in_ready, out_valid}, 3'b010);
      seen = 0;
      repeat (40) begin
         tick();
         if (out_valid || busy) seen++;
      end
      check("flush.no_result", seen, 0);
      do_op("after_flush", '{1'b0, 1'b0, 32'd100, 32'd7, 32'd14, NL});

      src1     = 32'd50;
      src2     = 32'd3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      resetn = 1'b0;
      #1;
      check("rst_mid.outputs", {in_ready, out_valid, busy, result}, {3'b100, 32'd0});
      #3;
      resetn = 1'b1;
      seen = 0;
      repeat (40) begin
         tick();
         if (out_valid || busy) seen++;
      end
      check("rst_mid.no_stale", seen, 0);
      do_op("after_rst", '{1'b0, 1'b1, 32'd7, 32'd2, 32'd1, NL});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width (minimum 4).
REQ-002 SHALL have clk  input  1  as the single clock, rising-edge.
REQ-003 SHALL have resetn  input  1  as the reset, asynchronous and active-low.
REQ-004 SHALL have in_valid  input  1  to request a new operation.
REQ-005 SHALL have in_ready  output  1  meaning the unit accepts a request this cycle.
REQ-006 SHALL have op_signed  input  1  selecting two's-complement (1) or unsigned (0) operands.
REQ-007 SHALL have op_rem  input  1  selecting remainder (1) or quotient (0) as the result.
REQ-008 SHALL have src1  input  WIDTH  as the dividend.
REQ-009 SHALL have src2  input  WIDTH  as the divisor.
REQ-010 SHALL have flush  input  1  to cancel any operation in flight.
REQ-011 SHALL have out_valid  output  1  meaning result is valid.
REQ-012 SHALL have out_ready  input  1  meaning the consumer takes the result.
REQ-013 SHALL have result  output  WIDTH  carrying the quotient or remainder.
REQ-014 SHALL have busy  output  1, high in any state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, CALC and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 SHALL accept a request on in_valid & in_ready & ~flush, latching |src1|, |src2|, op_signed, op_rem and the operand signs, then enter CALC.
REQ-017 SHALL perform one restoring shift-subtract iteration per CALC cycle, with a WIDTH-bit quotient register, a (WIDTH+1)-bit partial remainder and a counter of $clog2(WIDTH) bits.
REQ-018 SHALL enter DONE after exactly WIDTH CALC cycles, so that out_valid first rises WIDTH+1 cycles after the accepting edge (33 for WIDTH=32).
REQ-019 SHALL give the signed quotient the sign src1^src2 and the signed remainder the sign of src1, with the negation applied once when entering DONE.
REQ-020 SHALL, for signed MIN / -1, produce quotient MIN and remainder 0 with no special-case logic.
REQ-021 SHALL, for divisor zero, produce quotient all-ones and remainder = src1, for both signed and unsigned operations.
REQ-022 SHALL hold result and out_valid stable while out_valid & ~out_ready, and return to IDLE on the cycle after out_valid & out_ready.
REQ-023 SHALL NOT accept a new request in the same cycle as the result handshake; in_ready rises the cycle after.
REQ-024 SHALL, on flush in any state, enter IDLE on the next edge and discard the result; flush takes priority over in_valid and out_ready.
REQ-025 SHALL ignore src1, src2, op_signed and op_rem while not in IDLE.

Reset
REQ-026 SHALL, while resetn is low, force state=IDLE, in_ready=1, out_valid=0, busy=0, result=0 and the counter to 0, asynchronously.
REQ-027 SHALL, on reset mid-operation, drop the operation with no result emitted after reset is released.

Configuration
REQ-028 SHALL provide the macro ITER_DIV_ZERO_BYPASS_EN; when it is defined, a divisor-zero request goes from IDLE straight to DONE, with out_valid on the first cycle after the accepting edge.
REQ-029 SHALL, when ITER_DIV_ZERO_BYPASS_EN is undefined, run a divisor-zero request through the full WIDTH iterations and produce the same result values as REQ-021.

Structure
REQ-030 SHALL place the state enum (IDLE/CALC/DONE) and the DIV_W default constant in the shared package div_pkg.
REQ-031 SHALL use one combinational sub-module, div_step, that performs a single iteration: partial remainder in, shifted remainder and quotient bit out.

Verification
REQ-032 SHALL cover: unsigned 7/2, op_rem=0 then 1 -> result 3, then 1; out_valid exactly 33 cycles after acceptance.
REQ-033 SHALL cover: signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-034 SHALL cover: 5/0 signed and unsigned -> quotient 0xFFFFFFFF, remainder 5; latency 1 with the macro defined and 33 without it.
REQ-035 SHALL cover: out_ready held low for 10 cycles -> result and out_valid stable throughout, and in_ready=0 until the cycle after the handshake.
REQ-036 SHALL cover: flush at CALC cycle 5 while in_valid=1 -> IDLE next cycle, no out_valid, and the request is not accepted; a following 100/7 returns 14.
REQ-037 SHALL cover: resetn pulsed low during CALC -> outputs take their reset values immediately and no stale out_valid appears afterwards.
